// File: rtl/div_sequencer.sv
// Multi-cycle radix-2 restoring divider for MIPS DIV/DIVU, delivering LO/HI with a done strobe
// and stalling HI/LO reads while a division is in flight.
module div_sequencer #(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  unsigned_div,
  input  logic [DATA_WIDTH-1:0] operand_a,
  input  logic [DATA_WIDTH-1:0] operand_b,
  input  logic                  hilo_read,
  input  logic                  hilo_write_req,
  output logic                  busy,
  output logic                  stall,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] div_lo,
  output logic [DATA_WIDTH-1:0] div_hi,
  output logic                  div_by_zero
);

  localparam int unsigned CntW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  typedef enum logic [2:0] {StIdle, StPrep, StRun, StFix, StDone} state_e;

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic                  uns_q, uns_d;
  logic                  sign_q_q, sign_q_d, sign_r_q, sign_r_d;
  logic [DATA_WIDTH-1:0] rem_q, rem_d, quo_q, quo_d, dvs_q, dvs_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] lo_q, lo_d, hi_q, hi_d;
  logic                  dbz_q, dbz_d;

  logic                  a_neg, b_neg;
  logic [DATA_WIDTH-1:0] mag_a, mag_b;
  logic [DATA_WIDTH:0]   shifted;
  logic [DATA_WIDTH-1:0] diff;
  logic                  fits;

  always_comb begin
    a_neg   = ~uns_q & a_q[DATA_WIDTH-1];
    b_neg   = ~uns_q & b_q[DATA_WIDTH-1];
    // Negating the most negative value wraps back to itself, which is the correct magnitude.
    mag_a   = a_neg ? -a_q : a_q;
    mag_b   = b_neg ? -b_q : b_q;
    shifted = {rem_q, quo_q[DATA_WIDTH-1]};
    fits    = shifted >= {1'b0, dvs_q};
    // Result is below the divisor whenever it is used, so the low bits are exact.
    diff    = shifted[DATA_WIDTH-1:0] - dvs_q;
  end

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    uns_d    = uns_q;
    sign_q_d = sign_q_q;
    sign_r_d = sign_r_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    dvs_d    = dvs_q;
    cnt_d    = cnt_q;
    lo_d     = lo_q;
    hi_d     = hi_q;
    dbz_d    = dbz_q;

    if (state_q != StIdle && hilo_write_req) begin
      state_d = StIdle;
    end else if (start) begin
      a_d     = operand_a;
      b_d     = operand_b;
      uns_d   = unsigned_div;
      state_d = StPrep;
    end else begin
      unique case (state_q)
        StIdle: ;
        StPrep: begin
          sign_q_d = a_neg ^ b_neg;
          sign_r_d = a_neg;
          rem_d    = '0;
          quo_d    = mag_a;
          dvs_d    = mag_b;
          if (b_q == '0) begin
            lo_d    = '1;
            hi_d    = a_q;
            dbz_d   = 1'b1;
            state_d = StDone;
          end else begin
            dbz_d   = 1'b0;
            cnt_d   = CntW'(DATA_WIDTH - 1);
            state_d = StRun;
          end
        end
        StRun: begin
          rem_d = fits ? diff : shifted[DATA_WIDTH-1:0];
          quo_d = {quo_q[DATA_WIDTH-2:0], fits};
          if (cnt_q == '0) state_d = StFix;
          else             cnt_d = cnt_q - 1'b1;
        end
        StFix: begin
          lo_d    = sign_q_q ? -quo_q : quo_q;
          hi_d    = sign_r_q ? -rem_q : rem_q;
          state_d = StDone;
        end
        StDone: state_d = StIdle;
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      a_q      <= '0;
      b_q      <= '0;
      uns_q    <= 1'b0;
      sign_q_q <= 1'b0;
      sign_r_q <= 1'b0;
      rem_q    <= '0;
      quo_q    <= '0;
      dvs_q    <= '0;
      cnt_q    <= '0;
      lo_q     <= '0;
      hi_q     <= '0;
      dbz_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      uns_q    <= uns_d;
      sign_q_q <= sign_q_d;
      sign_r_q <= sign_r_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      dvs_q    <= dvs_d;
      cnt_q    <= cnt_d;
      lo_q     <= lo_d;
      hi_q     <= hi_d;
      dbz_q    <= dbz_d;
    end
  end

  assign busy        = state_q != StIdle;
  assign stall       = hilo_read & busy;
  assign done        = state_q == StDone;
  assign div_lo      = lo_q;
  assign div_hi      = hi_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_div_sequencer.sv
// Self-checking bench for div_sequencer: directed vector table, random operands against an
// arithmetic reference model, and hand-written stall/abort/reset/restart sequences.
module tb_div_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, unsigned_div, hilo_read, hilo_write_req;
  logic [31:0] operand_a, operand_b;
  logic        busy, stall, done, div_by_zero;
  logic [31:0] div_lo, div_hi;

  int errors = 0;
  int checks = 0;

  div_sequencer #(.DATA_WIDTH(32)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start          (start),
    .unsigned_div   (unsigned_div),
    .operand_a      (operand_a),
    .operand_b      (operand_b),
    .hilo_read      (hilo_read),
    .hilo_write_req (hilo_write_req),
    .busy           (busy),
    .stall          (stall),
    .done           (done),
    .div_lo         (div_lo),
    .div_hi         (div_hi),
    .div_by_zero    (div_by_zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        uns;
    logic [31:0] lo;
    logic [31:0] hi;
    logic        dbz;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: plain MIPS truncating division semantics.
  task automatic model(input logic [31:0] a, input logic [31:0] b, input logic uns,
                       output logic [31:0] lo, output logic [31:0] hi, output logic dbz);
    longint sa, sb, q, r;
    dbz = 1'b0;
    if (b == 0) begin
      lo = 32'hFFFF_FFFF; hi = a; dbz = 1'b1;
    end else if (uns) begin
      lo = a / b; hi = a % b;
    end else begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      q  = sa / sb;
      r  = sa % sb;
      lo = q[31:0];
      hi = r[31:0];
    end
  endtask

  task automatic next_cycle();
    @(posedge clk); #1;
  endtask

  // Entered idle, 1 time unit after an edge. Returns cycle number of done (cycle 0 = start).
  task automatic do_div(input logic [31:0] a, input logic [31:0] b, input logic uns,
                        output int lat, output logic dbz_c2);
    int c;
    start = 1'b1; operand_a = a; operand_b = b; unsigned_div = uns;
    next_cycle();
    start = 1'b0;
    operand_a = $urandom; operand_b = $urandom; unsigned_div = ~uns;
    c = 1;
    dbz_c2 = 1'bx;
    while (!done && c < 40) begin
      next_cycle();
      c++;
      if (c == 2) dbz_c2 = div_by_zero;
    end
    lat = c;
  endtask

  task automatic run_check(input string name, input logic [31:0] a, input logic [31:0] b,
                           input logic uns);
    logic [31:0] elo, ehi;
    logic        edbz, d2;
    int          lat;
    model(a, b, uns, elo, ehi, edbz);
    do_div(a, b, uns, lat, d2);
    check({name, " latency"}, 64'(lat), edbz ? 64'd2 : 64'd35);
    check({name, " lo"}, {32'h0, div_lo}, {32'h0, elo});
    check({name, " hi"}, {32'h0, div_hi}, {32'h0, ehi});
    check({name, " dbz"}, {63'h0, div_by_zero}, {63'h0, edbz});
    next_cycle();
    check({name, " busy after"}, {63'h0, busy}, 64'h0);
  endtask

  vec_t vecs[6];

  initial begin
    logic [31:0] elo, ehi;
    logic        edbz, d2, seen_done, bad;
    int          lat;

    vecs[0] = '{32'd100,        32'd7,          1'b1, 32'd14,         32'd2,         1'b0};
    vecs[1] = '{32'hFFFF_FFF9,  32'd2,          1'b0, 32'hFFFF_FFFD,  32'hFFFF_FFFF, 1'b0};
    vecs[2] = '{32'd7,          32'hFFFF_FFFE,  1'b0, 32'hFFFF_FFFD,  32'd1,         1'b0};
    vecs[3] = '{32'h8000_0000,  32'hFFFF_FFFF,  1'b0, 32'h8000_0000,  32'd0,         1'b0};
    vecs[4] = '{32'hFFFF_FFFF,  32'd1,          1'b1, 32'hFFFF_FFFF,  32'd0,         1'b0};
    vecs[5] = '{32'd55,         32'd0,          1'b1, 32'hFFFF_FFFF,  32'd55,        1'b1};

    rst_n = 1'b0; start = 1'b0; unsigned_div = 1'b0; operand_a = '0; operand_b = '0;
    hilo_read = 1'b0; hilo_write_req = 1'b0;
    #1;
    check("reset busy", {63'h0, busy}, 64'h0);
    check("reset done", {63'h0, done}, 64'h0);
    check("reset lo/hi", {div_lo, div_hi}, 64'h0);
    check("reset dbz", {63'h0, div_by_zero}, 64'h0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    next_cycle();

    for (int i = 0; i < 6; i++) begin
      do_div(vecs[i].a, vecs[i].b, vecs[i].uns, lat, d2);
      check($sformatf("vec%0d latency", i), 64'(lat), vecs[i].dbz ? 64'd2 : 64'd35);
      check($sformatf("vec%0d lo", i), {32'h0, div_lo}, {32'h0, vecs[i].lo});
      check($sformatf("vec%0d hi", i), {32'h0, div_hi}, {32'h0, vecs[i].hi});
      check($sformatf("vec%0d dbz", i), {63'h0, div_by_zero}, {63'h0, vecs[i].dbz});
      next_cycle();
      check($sformatf("vec%0d busy after", i), {63'h0, busy}, 64'h0);
    end

    // Flag set by the 55/0 above must drop once the next division's PREP completes.
    do_div(32'd9, 32'd3, 1'b1, lat, d2);
    check("dbz cleared after prep", {63'h0, d2}, 64'h0);
    check("9/3 lo", {32'h0, div_lo}, 64'd3);
    check("9/3 hi", {32'h0, div_hi}, 64'd0);
    next_cycle();

    for (int i = 0; i < 40; i++) begin
      logic [31:0] a, b;
      logic        u;
      a = $urandom;
      b = (i % 4 == 0) ? ($urandom & 32'hFF) : $urandom;
      if (i % 10 == 3) b = 32'hFFFF_FFFF;
      if (i % 13 == 5) b = 32'd0;
      u = 1'($urandom_range(0, 1));
      run_check($sformatf("rand%0d", i), a, b, u);
    end

    // Stall: hilo_read held from cycle 5; stall must cover cycles 5..35 and drop in 36.
    bad = 1'b0;
    start = 1'b1; operand_a = 32'd100; operand_b = 32'd7; unsigned_div = 1'b1;
    next_cycle();
    start = 1'b0;
    for (int c = 1; c <= 36; c++) begin
      hilo_read = (c >= 5);
      #1;
      if (c >= 5 && c <= 35 && stall !== 1'b1) bad = 1'b1;
      if (c == 35) check("stall div done cyc35", {63'h0, done}, 64'h1);
      if (c == 36) check("stall low cyc36", {63'h0, stall}, 64'h0);
      if (c < 36) begin @(posedge clk); #1; end
    end
    check("stall held 5..35", {63'h0, bad}, 64'h0);
    check("stall div lo", {32'h0, div_lo}, 64'd14);
    hilo_read = 1'b0;
    next_cycle();

    // Abort in cycle 10: idle in cycle 11, no done, outputs unchanged (14, 2, 0).
    start = 1'b1; operand_a = 32'h1234; operand_b = 32'd5; unsigned_div = 1'b1;
    next_cycle();
    start = 1'b0;
    seen_done = 1'b0;
    for (int c = 1; c < 10; c++) begin
      if (done) seen_done = 1'b1;
      next_cycle();
    end
    hilo_write_req = 1'b1;
    next_cycle();
    hilo_write_req = 1'b0;
    check("abort busy cyc11", {63'h0, busy}, 64'h0);
    for (int c = 0; c < 40; c++) begin
      if (done) seen_done = 1'b1;
      next_cycle();
    end
    check("abort no done", {63'h0, seen_done}, 64'h0);
    check("abort lo/hi kept", {div_lo, div_hi}, {32'd14, 32'd2});
    check("abort dbz kept", {63'h0, div_by_zero}, 64'h0);

    // Async reset in cycle 20, then full latency after release.
    start = 1'b1; operand_a = 32'd500; operand_b = 32'd9; unsigned_div = 1'b1;
    next_cycle();
    start = 1'b0;
    repeat (19) next_cycle();
    #2 rst_n = 1'b0;
    #1;
    check("rst busy", {63'h0, busy}, 64'h0);
    check("rst done", {63'h0, done}, 64'h0);
    check("rst lo/hi", {div_lo, div_hi}, 64'h0);
    check("rst dbz", {63'h0, div_by_zero}, 64'h0);
    next_cycle();
    rst_n = 1'b1;
    next_cycle();
    run_check("post-reset 100/7", 32'd100, 32'd7, 1'b1);

    // Restart in cycle 15: only the new division completes, 35 cycles later.
    start = 1'b1; operand_a = 32'd1000; operand_b = 32'd3; unsigned_div = 1'b1;
    next_cycle();
    start = 1'b0;
    seen_done = 1'b0;
    for (int c = 1; c < 15; c++) begin
      if (done) seen_done = 1'b1;
      next_cycle();
    end
    start = 1'b1; operand_a = 32'hFFFF_FFB3; operand_b = 32'd5; unsigned_div = 1'b0;
    next_cycle();
    start = 1'b0;
    lat = 1;
    while (!done && lat < 40) begin
      next_cycle();
      lat++;
    end
    model(32'hFFFF_FFB3, 32'd5, 1'b0, elo, ehi, edbz);
    check("restart no early done", {63'h0, seen_done}, 64'h0);
    check("restart latency", 64'(lat), 64'd35);
    check("restart lo/hi", {div_lo, div_hi}, {elo, ehi});
    next_cycle();
    check("restart done single", {63'h0, done}, 64'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
